// File: rtl/cla_restoring_divider_if.sv
`default_nettype none
// ============================================================================
//  Module   : cla_restoring_divider_if
//  Brief    : Operand/result handshake bundle for the restoring divider.
//  Revision : 1.0  initial release
// ============================================================================
interface cla_restoring_divider_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             busy;

  // Requester side: presents operands, consumes results.
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );

  // Divider side.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );
endinterface
`default_nettype wire

// File: rtl/cla_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : cla_restoring_divider
//  Brief    : Unsigned restoring divider, one quotient bit per cycle, with the
//             trial subtraction built from 4-bit carry-lookahead groups.
//             WIDTH must be a multiple of 4.
//  Revision : 1.0  initial release
// ============================================================================
module cla_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cla_restoring_divider_if.slave bus
);

  localparam int NG = WIDTH / 4;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] dvd_sh;       // dividend, shifted out MSB first
  logic [WIDTH-1:0] dvs_r;        // captured divisor
  logic [WIDTH:0]   rem_r;        // partial remainder
  logic [WIDTH-1:0] quo_sh;       // quotient bits as they are produced
  logic [CW-1:0]    cnt;          // iteration count
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_r;

  logic             accept;
  logic             last_iter;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] cla_x, cla_y, cla_sum;
  logic             carry_w;      // carry into bit WIDTH of the trial
  logic             trial_cout;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] quo_nx;

  assign accept    = bus.in_valid && (state == IDLE);
  assign last_iter = (cnt == LAST_ITER);

  // Trial: R - divisor, computed as R + ~{0,divisor} + 1.
  assign r_shift = {rem_r[WIDTH-1:0], dvd_sh[WIDTH-1]};
  assign cla_x   = r_shift[WIDTH-1:0];
  assign cla_y   = ~dvs_r;

  for (genvar k = 0; k < NG; k++) begin : g_cla
    logic [3:0] g, p, c;
    logic       cin, gg, gp, cout;
    if (k == 0) begin : g_first
      assign cin = 1'b1;
    end else begin : g_next
      assign cin = g_cla[k-1].cout;
    end
    assign g = cla_x[4*k +: 4] & cla_y[4*k +: 4];
    assign p = cla_x[4*k +: 4] ^ cla_y[4*k +: 4];
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
    assign gp   = &p;
    assign cout = gg | (gp & cin);
    assign cla_sum[4*k +: 4] = p ^ c;
  end

  // Top bit: the extended divisor bit is 0, so its complement is 1.
  assign carry_w    = g_cla[NG-1].cout;
  assign trial_cout = r_shift[WIDTH] | carry_w;
  assign trial      = {~r_shift[WIDTH] ^ carry_w, cla_sum};
  assign rem_nx     = trial_cout ? trial : r_shift;
  assign quo_nx     = {quo_sh[WIDTH-2:0], trial_cout};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode; a zero divisor skips the iterations entirely.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.in_valid) state_nx = (bus.divisor == '0) ? DONE : CALC;
      CALC: if (last_iter)    state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, one restoring step per CALC cycle, result load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_sh      <= '0;
      dvs_r       <= '0;
      rem_r       <= '0;
      quo_sh      <= '0;
      cnt         <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      if (accept) begin
        dvd_sh <= bus.dividend;
        dvs_r  <= bus.divisor;
        rem_r  <= '0;
        quo_sh <= '0;
        cnt    <= '0;
        if (bus.divisor == '0) begin
          quotient_r  <= '1;
          remainder_r <= bus.dividend;
          dbz_r       <= 1'b1;
        end
      end else if (state == CALC) begin
        rem_r  <= rem_nx;
        dvd_sh <= dvd_sh << 1;
        quo_sh <= quo_nx;
        cnt    <= cnt + 1'b1;
        if (last_iter) begin
          quotient_r  <= quo_nx;
          remainder_r <= rem_nx[WIDTH-1:0];
          dbz_r       <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.busy        = (state != IDLE);
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;

endmodule
`default_nettype wire

// File: tb/tb_cla_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla_restoring_divider
//  Brief    : Directed self-checking bench for cla_restoring_divider, WIDTH=4.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cla_restoring_divider;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  cla_restoring_divider_if #(.WIDTH(WIDTH)) bus ();

  cla_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Present one operation and wait for its result; lat counts edges after the
  // accept edge until out_valid is seen. When ack=1 the result is consumed.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit ack,
                        output logic [3:0] q, output logic [3:0] r,
                        output logic z, output int lat);
    int guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    bus.in_valid = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.dividend = ~a; bus.divisor = ~b;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.out_valid && lat < 20);
    q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
    if (ack) begin
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [3:0] q, r; logic z; int lat;
    #2;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    total++; if ({bus.quotient, bus.remainder, bus.div_by_zero} !== 9'd0) begin bad++;
      $display("FAIL rst_outputs got q=%0d r=%0d z=%b want all 0", bus.quotient, bus.remainder, bus.div_by_zero); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
    // first edge after release must accept
    bus.in_valid = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL first_accept busy got=%b want=1", bus.busy); end
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus.out_valid && lat < 20);
    bus.out_ready = 1'b1; @(posedge clk); #1; bus.out_ready = 1'b0;
    // reuse run_op variables to silence nothing: next op checks latency itself
    q = 4'd0; r = 4'd0; z = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] q, r; logic z; int lat;
    run_op(4'd13, 4'd3, 1'b1, q, r, z, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL basic_latency got=%0d want=4", lat); end
    total++; if (q !== 4'd4) begin bad++; $display("FAIL basic_quot got=%0d want=4", q); end
    total++; if (r !== 4'd1) begin bad++; $display("FAIL basic_rem got=%0d want=1", r); end
    total++; if (z !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b want=0", z); end
    total++; if (bus.out_valid !== 1'b0 || bus.quotient !== 4'd4 || bus.remainder !== 4'd1) begin bad++;
      $display("FAIL basic_after_handoff got v=%b q=%0d r=%0d want v=0 q=4 r=1", bus.out_valid, bus.quotient, bus.remainder); end
  endtask

  task automatic test_vectors();
    logic [3:0] a_t [3] = '{4'd15, 4'd3, 4'd15};
    logic [3:0] b_t [3] = '{4'd1,  4'd9, 4'd15};
    logic [3:0] q_t [3] = '{4'd15, 4'd0, 4'd1};
    logic [3:0] r_t [3] = '{4'd0,  4'd3, 4'd0};
    logic [3:0] q, r; logic z; int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(a_t[i], b_t[i], 1'b1, q, r, z, lat);
      total++; if (q !== q_t[i] || r !== r_t[i] || z !== 1'b0 || lat !== 4) begin bad++;
        $display("FAIL vec_%0d_%0d got q=%0d r=%0d z=%b lat=%0d want q=%0d r=%0d z=0 lat=4",
                 a_t[i], b_t[i], q, r, z, lat, q_t[i], r_t[i]); end
    end
  endtask

  task automatic test_div_zero();
    logic [3:0] q, r; logic z; int lat;
    run_op(4'd7, 4'd0, 1'b1, q, r, z, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL dbz_latency got=%0d want=1", lat); end
    total++; if (q !== 4'd15 || r !== 4'd7 || z !== 1'b1) begin bad++;
      $display("FAIL dbz_result got q=%0d r=%0d z=%b want q=15 r=7 z=1", q, r, z); end
  endtask

  task automatic test_backpressure();
    logic [3:0] q, r; logic z; int lat;
    run_op(4'd13, 4'd3, 1'b0, q, r, z, lat);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== 4'd4 ||
                   bus.remainder !== 4'd1 || bus.div_by_zero !== 1'b0) begin bad++;
        $display("FAIL hold_%0d got v=%b rdy=%b q=%0d r=%0d z=%b want v=1 rdy=0 q=4 r=1 z=0",
                 i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin bad++;
      $display("FAIL hold_release got v=%b rdy=%b busy=%b want v=0 rdy=1 busy=0", bus.out_valid, bus.in_ready, bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] q, r; logic z; int lat;
    // in_valid stays high through the whole operation and the handoff
    bus.in_valid = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd4;
    @(posedge clk); #1;
    bus.dividend = 4'd5; bus.divisor = 4'd0;   // must be ignored while busy
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus.out_valid && lat < 20);
    total++; if (bus.quotient !== 4'd3 || bus.remainder !== 4'd2 || lat !== 4) begin bad++;
      $display("FAIL b2b_first got q=%0d r=%0d lat=%0d want q=3 r=2 lat=4", bus.quotient, bus.remainder, lat); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin bad++;
      $display("FAIL b2b_handoff_no_accept got busy=%b rdy=%b want busy=0 rdy=1", bus.busy, bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b1) begin bad++;
      $display("FAIL b2b_second_accept got busy=%b v=%b want busy=1 v=1", bus.busy, bus.out_valid); end
    total++; if (bus.quotient !== 4'd15 || bus.remainder !== 4'd5 || bus.div_by_zero !== 1'b1) begin bad++;
      $display("FAIL b2b_second got q=%0d r=%0d z=%b want q=15 r=5 z=1", bus.quotient, bus.remainder, bus.div_by_zero); end
    bus.out_ready = 1'b1; @(posedge clk); #1; bus.out_ready = 1'b0;
    q = 4'd0; r = 4'd0; z = 1'b0;
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    bus.in_valid = 1'b1; bus.dividend = 4'd9; bus.divisor = 4'd2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== 4'd0 ||
                 bus.remainder !== 4'd0 || bus.div_by_zero !== 1'b0) begin bad++;
      $display("FAIL abort_outputs got v=%b busy=%b q=%0d r=%0d z=%b want all 0",
               bus.out_valid, bus.busy, bus.quotient, bus.remainder, bus.div_by_zero); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_pulse got=%0d want=0", seen); end
  endtask

  task automatic test_exhaustive();
    logic [3:0] q, r; logic z; int lat;
    int errs = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), 1'b1, q, r, z, lat);
        total++;
        if (b == 0) begin
          if (q !== 4'd15 || int'(r) != a || z !== 1'b1 || lat != 1) begin
            bad++; errs++;
            if (errs < 10) $display("FAIL exh_%0d_%0d got q=%0d r=%0d z=%b lat=%0d want q=15 r=%0d z=1 lat=1", a, b, q, r, z, lat, a);
          end
        end else begin
          if (int'(q) * b + int'(r) != a || int'(r) >= b || z !== 1'b0 || lat != 4) begin
            bad++; errs++;
            if (errs < 10) $display("FAIL exh_%0d_%0d got q=%0d r=%0d z=%b lat=%0d want q=%0d r=%0d z=0 lat=4", a, b, q, r, z, lat, a / b, a % b);
          end
        end
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.dividend = '0; bus.divisor = '0; bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
